// File: rtl/slink_apb_ini_core.sv
// S-Link APB initiator: turns link request packets into APB master transfers and returns responses.
// Optional ACCESS-phase timeout enabled by defining SLINK_APB_INI_TIMEOUT_EN.
module slink_apb_ini_core #(
  parameter logic [7:0] APB_READ_DT      = 8'h24,
  parameter logic [7:0] APB_READ_RSP_DT  = 8'h25,
  parameter logic [7:0] APB_WRITE_DT     = 8'h26,
  parameter logic [7:0] APB_WRITE_RSP_DT = 8'h27,
  parameter int         APB_TIMEOUT      = 256
) (
  input  logic        apb_clk,
  input  logic        apb_reset_n,
  input  logic        enable,
  input  logic        l2a_valid,
  input  logic [87:0] l2a_data,
  output logic        l2a_accept,
  output logic        a2l_valid,
  output logic [56:0] a2l_data,
  input  logic        a2l_ready,
  output logic [31:0] apb_paddr,
  output logic        apb_pwrite,
  output logic        apb_psel,
  output logic        apb_penable,
  output logic [31:0] apb_pwdata,
  input  logic [31:0] apb_prdata,
  input  logic        apb_pready,
  input  logic        apb_pslverr,
  output logic        invalid_req_pkt,
  output logic        apb_timeout
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t      state_reg;
  logic [7:0]  req_dt;
  logic        req_read;
  logic        req_write;
  logic        timeout_hit;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [56:0] rsp_data;
  logic        unused_wc;

  assign req_dt     = l2a_data[7:0];
  assign req_read   = (req_dt == APB_READ_DT);
  assign req_write  = (req_dt == APB_WRITE_DT);
  assign unused_wc  = ^l2a_data[23:8];
  assign l2a_accept = (state_reg == IDLE) && enable && l2a_valid;

`ifdef SLINK_APB_INI_TIMEOUT_EN
  localparam int TMO_W = (APB_TIMEOUT > 2) ? $clog2(APB_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(APB_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt_reg;

  // Counts ACCESS cycles spent waiting on pready; restarts on every SETUP.
  always_ff @(posedge apb_clk) begin
    if (!apb_reset_n) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == SETUP) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ACCESS && !apb_pready) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  // pready on the final cycle wins over the timeout.
  assign timeout_hit = (state_reg == ACCESS) && !apb_pready && (tmo_cnt_reg == TMO_LAST);
`else
  localparam int unused_timeout = APB_TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    rsp_err   = timeout_hit ? 1'b1 : apb_pslverr;
    rsp_rdata = timeout_hit ? 32'h0 : apb_prdata;
    if (apb_pwrite) begin
      rsp_data = {32'h0, rsp_err, 16'd1, APB_WRITE_RSP_DT};
    end else begin
      rsp_data = {rsp_err, rsp_rdata, 16'd5, APB_READ_RSP_DT};
    end
  end

  always_ff @(posedge apb_clk) begin
    if (!apb_reset_n) begin
      state_reg       <= IDLE;
      apb_paddr       <= '0;
      apb_pwrite      <= 1'b0;
      apb_psel        <= 1'b0;
      apb_penable     <= 1'b0;
      apb_pwdata      <= '0;
      a2l_valid       <= 1'b0;
      a2l_data        <= '0;
      invalid_req_pkt <= 1'b0;
      apb_timeout     <= 1'b0;
    end else begin
      invalid_req_pkt <= 1'b0;
      apb_timeout     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (l2a_accept) begin
            if (req_read || req_write) begin
              apb_paddr  <= l2a_data[55:24];
              apb_pwdata <= l2a_data[87:56];
              apb_pwrite <= req_write;
              apb_psel   <= 1'b1;
              state_reg  <= SETUP;
            end else begin
              invalid_req_pkt <= 1'b1;
            end
          end
        end
        SETUP: begin
          apb_penable <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (apb_pready || timeout_hit) begin
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            a2l_valid   <= 1'b1;
            a2l_data    <= rsp_data;
            apb_timeout <= timeout_hit;
            state_reg   <= RESP;
          end
        end
        RESP: begin
          if (a2l_ready) begin
            a2l_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slink_apb_ini_core.sv
// Randomized bench for slink_apb_ini_core: drives request packets, acts as APB slave,
// and checks APB phases and response packets against a transaction-level model.
module tb_slink_apb_ini_core;

  logic        apb_clk = 1'b0;
  logic        apb_reset_n;
  logic        enable;
  logic        l2a_valid;
  logic [87:0] l2a_data;
  logic        l2a_accept;
  logic        a2l_valid;
  logic [56:0] a2l_data;
  logic        a2l_ready;
  logic [31:0] apb_paddr;
  logic        apb_pwrite;
  logic        apb_psel;
  logic        apb_penable;
  logic [31:0] apb_pwdata;
  logic [31:0] apb_prdata;
  logic        apb_pready;
  logic        apb_pslverr;
  logic        invalid_req_pkt;
  logic        apb_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 apb_clk = ~apb_clk;
  always @(posedge apb_clk) cyc <= cyc + 1;

  slink_apb_ini_core dut (
    .apb_clk        (apb_clk),
    .apb_reset_n    (apb_reset_n),
    .enable         (enable),
    .l2a_valid      (l2a_valid),
    .l2a_data       (l2a_data),
    .l2a_accept     (l2a_accept),
    .a2l_valid      (a2l_valid),
    .a2l_data       (a2l_data),
    .a2l_ready      (a2l_ready),
    .apb_paddr      (apb_paddr),
    .apb_pwrite     (apb_pwrite),
    .apb_psel       (apb_psel),
    .apb_penable    (apb_penable),
    .apb_pwdata     (apb_pwdata),
    .apb_prdata     (apb_prdata),
    .apb_pready     (apb_pready),
    .apb_pslverr    (apb_pslverr),
    .invalid_req_pkt(invalid_req_pkt),
    .apb_timeout    (apb_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response packet as a number: DT + WC*2^8 + payload*2^24.
  function automatic logic [63:0] model_rsp(input bit is_write, input logic [31:0] rdata, input bit err);
    logic [63:0] payload;
    if (is_write) begin
      payload = 64'(err);
      return payload * 64'h100_0000 + 64'd1 * 64'h100 + 64'h27;
    end
    payload = 64'(rdata) + 64'(err) * 64'h1_0000_0000;
    return payload * 64'h100_0000 + 64'd5 * 64'h100 + 64'h25;
  endfunction

  initial begin
    logic [7:0]  dt;
    logic [15:0] wc;
    logic [31:0] addr, wdata, rdata;
    logic [63:0] exp_data;
    bit          is_bad, is_write, err, mid_dis;
    int          waits, bp, acc_cyc;

    apb_reset_n = 1'b0; enable = 1'b0; l2a_valid = 1'b0; l2a_data = '0;
    a2l_ready = 1'b0; apb_prdata = '0; apb_pready = 1'b0; apb_pslverr = 1'b0;
    repeat (3) @(negedge apb_clk);
    check("rst_psel", 64'(apb_psel), 64'd0);
    check("rst_penable", 64'(apb_penable), 64'd0);
    check("rst_paddr", 64'(apb_paddr), 64'd0);
    check("rst_a2l_valid", 64'(a2l_valid), 64'd0);
    check("rst_a2l_data", 64'(a2l_data), 64'd0);
    check("rst_invalid", 64'(invalid_req_pkt), 64'd0);
    check("rst_timeout", 64'(apb_timeout), 64'd0);
    apb_reset_n = 1'b1;
    @(negedge apb_clk);

    for (int t = 0; t < 40; t++) begin
      wc = 16'($urandom);
      addr = $urandom; wdata = $urandom; rdata = $urandom;
      err = 1'($urandom); waits = $urandom_range(0, 4); bp = $urandom_range(0, 3);
      mid_dis = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       begin do dt = 8'($urandom); while (dt == 8'h24 || dt == 8'h26); end
        1, 2, 3, 4: dt = 8'h26;
        default: dt = 8'h24;
      endcase
      if (t == 0) begin dt = 8'h24; addr = 32'h1000; rdata = 32'hDEAD_BEEF; err = 1'b0; waits = 0; bp = 10; end
      if (t == 1) begin dt = 8'h26; addr = 32'h40; wdata = 32'h1234_5678; err = 1'b1; waits = 4; end
      if (t == 2) dt = 8'h55;
      is_bad   = (dt != 8'h24) && (dt != 8'h26);
      is_write = (dt == 8'h26);

      l2a_valid = 1'b1;
      l2a_data  = {wdata, addr, wc, dt};
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          check("disabled_accept", 64'(l2a_accept), 64'd0);
          check("disabled_psel", 64'(apb_psel), 64'd0);
          @(negedge apb_clk);
        end
      end
      enable = 1'b1;
      #1;
      check("accept", 64'(l2a_accept), 64'd1);
      acc_cyc = cyc;
      @(negedge apb_clk);
      l2a_valid = 1'b0;
      if (mid_dis) enable = 1'b0;

      if (is_bad) begin
        check("invalid_pulse", 64'(invalid_req_pkt), 64'd1);
        check("invalid_psel", 64'(apb_psel), 64'd0);
        @(negedge apb_clk);
        check("invalid_clear", 64'(invalid_req_pkt), 64'd0);
        check("invalid_no_rsp", 64'(a2l_valid), 64'd0);
        check("invalid_no_psel", 64'(apb_psel), 64'd0);
        $display("txn %0d: bad DT 0x%0h dropped", t, dt);
        enable = 1'b1;
        continue;
      end

      check("setup_psel", 64'(apb_psel), 64'd1);
      check("setup_penable", 64'(apb_penable), 64'd0);
      check("setup_paddr", 64'(apb_paddr), 64'(addr));
      check("setup_pwrite", 64'(apb_pwrite), 64'(is_write));
      if (is_write) check("setup_pwdata", 64'(apb_pwdata), 64'(wdata));
      for (int w = 0; w <= waits; w++) begin
        @(negedge apb_clk);
        check("access_psel", 64'({apb_psel, apb_penable}), 64'd3);
        check("access_paddr", 64'(apb_paddr), 64'(addr));
        if (is_write) check("access_pwdata", 64'(apb_pwdata), 64'(wdata));
        check("access_no_rsp", 64'(a2l_valid), 64'd0);
        apb_pready  = (w == waits);
        apb_prdata  = (w == waits) ? rdata : 32'($urandom);
        apb_pslverr = (w == waits) ? err : 1'($urandom);
      end
      @(negedge apb_clk);
      apb_pready = 1'b0;
      exp_data = model_rsp(is_write, rdata, err);
      check("rsp_psel", 64'({apb_psel, apb_penable}), 64'd0);
      check("rsp_valid", 64'(a2l_valid), 64'd1);
      check("rsp_data", 64'(a2l_data), exp_data);
      check("rsp_latency", 64'(cyc - acc_cyc), 64'(3 + waits));
      check("rsp_no_timeout", 64'(apb_timeout), 64'd0);

      enable = 1'b1;
      l2a_valid = 1'b1;
      l2a_data  = {32'h0, 32'h0, 16'h0, 8'h24};
      for (int k = 0; k < bp; k++) begin
        a2l_ready = 1'b0;
        #1;
        check("bp_accept", 64'(l2a_accept), 64'd0);
        check("bp_valid", 64'(a2l_valid), 64'd1);
        check("bp_data", 64'(a2l_data), exp_data);
        @(negedge apb_clk);
      end
      a2l_ready = 1'b1;
      #1;
      check("hs_accept", 64'(l2a_accept), 64'd0);
      @(negedge apb_clk);
      check("post_hs_valid", 64'(a2l_valid), 64'd0);
      check("post_hs_accept", 64'(l2a_accept), 64'd1);
      a2l_ready = 1'b0;
      l2a_valid = 1'b0;
      $display("txn %0d: %s addr 0x%0h waits %0d bp %0d rsp 0x%0h", t, is_write ? "write" : "read",
               addr, waits, bp, exp_data);
    end

    // Reset in the middle of ACCESS returns everything to idle.
    l2a_valid = 1'b1;
    l2a_data  = {32'h0, 32'hABCD_0000, 16'h5, 8'h24};
    @(negedge apb_clk);
    l2a_valid = 1'b0;
    repeat (3) @(negedge apb_clk);
    check("mid_access_psel", 64'({apb_psel, apb_penable}), 64'd3);
    apb_reset_n = 1'b0;
    @(negedge apb_clk);
    check("reset_psel", 64'(apb_psel), 64'd0);
    check("reset_penable", 64'(apb_penable), 64'd0);
    check("reset_a2l_valid", 64'(a2l_valid), 64'd0);
    apb_reset_n = 1'b1;
    @(negedge apb_clk);
    l2a_valid = 1'b1;
    #1;
    check("reset_idle_accept", 64'(l2a_accept), 64'd1);
    l2a_valid = 1'b0;
    $display("txn reset: mid-ACCESS reset returned to idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
